// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write side.
// Gray conversion is width-agnostic; callers truncate to their pointer width.
package fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wr_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority selector: first set request at or after rr_ptr_i, with wrap.
// Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the farthest offset down so the closest match to rr_ptr_i wins.
  always_comb begin
    int j;
    j       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller: round-robin, burst-bounded sharing of the FIFO memory write port.
// Owns the binary/Gray write pointer and the registered full flag; grants are same-cycle.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1),
  localparam int PW = ADDR_SIZE + 1
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [PW-1:0]                wq2_rptr,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [IW-1:0]                owner,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic [ADDR_SIZE-1:0]         waddr,
  output logic                         wclk_en,
  output logic [PW-1:0]                wptr,
  output logic                         wfull
);

  wr_state_e     state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic          wfull_q, wfull_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          write;
  logic [IW-1:0] sel;

  function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  // Reset gates the grant so nothing is written while wrst_n is low.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    if (wrst_n && !wfull_q) begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt[pick_idx] = 1'b1;
            owner_d       = pick_idx;
            cnt_d         = BW'(1);
            if (MAX_BURST == 1) rr_d = nxt_idx(pick_idx);
            else                state_d = BURST;
          end
        end
        BURST: begin
          if (req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            cnt_d        = cnt_q + BW'(1);
            if (cnt_q + BW'(1) == BW'(MAX_BURST)) begin
              state_d = IDLE;
              rr_d    = nxt_idx(owner_q);
            end
          end else begin
            state_d = IDLE;
            rr_d    = nxt_idx(owner_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign write   = |gnt;
  assign wbin_d  = wbin_q + PW'(write);
  assign wgray_d = PW'(bin2gray(32'(wbin_d)));
  assign wfull_d = (wgray_d == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]});

  assign sel     = (state_q == IDLE && write) ? pick_idx : owner_q;
  assign wdata   = req_data[sel*DATA_SIZE +: DATA_SIZE];
  assign wclk_en = write;
  assign waddr   = wbin_q[ADDR_SIZE-1:0];
  assign wptr    = wptr_q;
  assign wfull   = wfull_q;
  assign owner   = owner_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboarded bench for fifo_wr_arbiter: a behavioural model pushes per-cycle expectations,
// an independent monitor pops and compares them against the DUT outputs.
module tb_fifo_wr_arbiter;

  localparam int DS = 8;
  localparam int AS = 4;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int DEPTH = 1 << AS;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic [NR-1:0]   req;
  logic [NR*DS-1:0] req_data;
  logic [AS:0]     wq2_rptr;
  logic [NR-1:0]   gnt;
  logic [1:0]      owner;
  logic [DS-1:0]   wdata;
  logic [AS-1:0]   waddr;
  logic            wclk_en;
  logic [AS:0]     wptr;
  logic            wfull;

  fifo_wr_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .wq2_rptr(wq2_rptr),
    .gnt(gnt), .owner(owner), .wdata(wdata), .waddr(waddr), .wclk_en(wclk_en),
    .wptr(wptr), .wfull(wfull)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit         wen;
    logic [3:0] gnt;
    logic [7:0] data;
    logic [3:0] addr;
    logic [4:0] wptr;
    bit         wfull;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Requester and reader stimulus state
  bit         pend[NR];
  bit         acc[NR];
  logic [7:0] word[NR];
  logic [3:0] mask = 4'b1111;
  int         p_req = 0;
  int         rd_prob = 0;

  // Reference model: write/read counts, who owns the port and how many beats it has used
  int wr_cnt = 0, rd_cnt = 0;
  bit full_m = 0;
  int next_pri = 0, own_m = 0, beats = 0;
  bit in_burst = 0;

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_cnt = 0; rd_cnt = 0; full_m = 0;
    next_pri = 0; own_m = 0; beats = 0; in_burst = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int   g;
    g      = -1;
    e.addr = 4'(wr_cnt % DEPTH);
    e.wptr = gray5(wr_cnt % (2 * DEPTH));
    e.wfull = full_m;
    if (!full_m) begin
      if (!in_burst) begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (next_pri + k) % NR;
          if (g < 0 && req[j]) g = j;
        end
        if (g >= 0) begin
          own_m = g; beats = 1; in_burst = 1;
        end
      end else if (req[own_m]) begin
        g = own_m;
        beats++;
        if (beats == MB) begin
          in_burst = 0; next_pri = (own_m + 1) % NR;
        end
      end else begin
        in_burst = 0; next_pri = (own_m + 1) % NR;
      end
    end
    e.wen  = (g >= 0);
    e.gnt  = (g >= 0) ? 4'(1 << g) : 4'b0;
    e.data = (g >= 0) ? req_data[g*DS +: DS] : 8'h0;
    if (g >= 0) wr_cnt++;
    full_m = ((wr_cnt - rd_cnt) == DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) pend[i] = 0;
      acc[i] = 0;
      if (!pend[i] && mask[i] && ($urandom % 100) < p_req) begin
        pend[i] = 1;
        word[i] = 8'($urandom);
      end
      req[i] = pend[i];
      req_data[i*DS +: DS] = word[i];
    end
    if (rd_cnt < wr_cnt && ($urandom % 100) < rd_prob) rd_cnt++;
    wq2_rptr = gray5(rd_cnt);
  endtask

  task automatic sample();
    for (int i = 0; i < NR; i++) acc[i] = req[i] & gnt[i];
    model_step();
  endtask

  task automatic cycle();
    @(posedge wclk); #1;
    drive();
    @(negedge wclk);
    sample();
  endtask

  // Monitor: one expectation per sampled cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (wclk_en !== e.wen || gnt !== e.gnt || (e.wen && wdata !== e.data)) begin
          n_fail++;
          $display("FAIL grant: got en=%0b gnt=%b data=%0h expected en=%0b gnt=%b data=%0h at %0t",
                   wclk_en, gnt, wdata, e.wen, e.gnt, e.data, $time);
        end
        n_tests++;
        if (waddr !== e.addr || wptr !== e.wptr || wfull !== e.wfull) begin
          n_fail++;
          $display("FAIL ptr: got addr=%0h wptr=%b full=%0b expected addr=%0h wptr=%b full=%0b at %0t",
                   waddr, wptr, wfull, e.addr, e.wptr, e.wfull, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit reached;
    int k;
    for (int i = 0; i < NR; i++) begin pend[i] = 0; acc[i] = 0; word[i] = '0; end
    wrst_n   = 1'b0;
    req      = 4'b1111;
    req_data = 32'h44332211;
    wq2_rptr = '0;
    #12;
    chk("reset_gnt",   32'(gnt), 0);
    chk("reset_wen",   32'(wclk_en), 0);
    chk("reset_waddr", 32'(waddr), 0);
    chk("reset_wptr",  32'(wptr), 0);
    chk("reset_wfull", 32'(wfull), 0);
    req = '0;
    #10 wrst_n = 1'b1;

    // All four requesters saturating, reader stalled: 4 beats each then full
    mask = 4'b1111; p_req = 100; rd_prob = 0;
    repeat (20) cycle();
    chk("rr_full", 32'(wfull), 1);
    chk("rr_stall_gnt", 32'(gnt), 0);

    // Random traffic with a draining reader
    p_req = 60; rd_prob = 50;
    repeat (2000) cycle();

    // Quiesce: no new requests, drain everything
    p_req = 0; rd_prob = 100;
    k = 0;
    while (k < 300 && (pend[0] || pend[1] || pend[2] || pend[3] || rd_cnt != wr_cnt)) begin
      cycle();
      k++;
    end
    chk("drain_done", 32'(rd_cnt == wr_cnt), 1);

    // Burst from requester 1, then reset during its third beat
    mask = 4'b0010; p_req = 100; rd_prob = 0;
    reached = 0;
    for (int n = 0; n < 50 && !reached; n++) begin
      cycle();
      if (in_burst && own_m == 1 && beats == 2) reached = 1;
    end
    chk("burst_reached", 32'(reached), 1);
    @(posedge wclk); #1;
    drive();
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 0);
    chk("rst_mid_wen", 32'(wclk_en), 0);
    chk("rst_mid_waddr", 32'(waddr), 0);
    @(negedge wclk);
    for (int i = 0; i < NR; i++) acc[i] = 0;
    model_reset();
    req = '0;
    wq2_rptr = '0;
    @(negedge wclk); #2;
    wrst_n = 1'b1;
    mask = 4'b1111;
    cycle();
    chk("first_after_reset", 32'(gnt), 32'h1);
    repeat (12) cycle();

    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
